// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit microprocessor: instruction/data widths,
// opcode and ALU function encodings, and the sequencer state encoding.
package cpu4_pkg;

  localparam int INSTR_W = 8;
  localparam int DATA_W  = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_OR     = 3'd4;
  localparam logic [2:0] ALU_XOR    = 3'd5;
  localparam logic [2:0] ALU_NOT_A  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_EXEC      = 3'd2,
    S_WRITE     = 3'd3,
    S_HALT      = 3'd4,
    S_STEP_WAIT = 3'd5
  } state_t;

endpackage

// File: rtl/cpu4_dec.sv
// Combinational instruction decoder: opcode -> ALU function and control
// flags. Opcodes A-E are illegal and decode exactly like NOP.
import cpu4_pkg::*;

module cpu4_dec (
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       writes_acc_o,
  output logic       is_jmp_o,
  output logic       is_jz_o,
  output logic       is_hlt_o
);

  // Table lookup from opcode to control bundle; anything unlisted is a NOP.
  always_comb begin
    alu_op_o     = ALU_PASS_B;
    writes_acc_o = 1'b0;
    is_jmp_o     = 1'b0;
    is_jz_o      = 1'b0;
    is_hlt_o     = 1'b0;
    case (opcode_i)
      OP_LDI: begin alu_op_o = ALU_PASS_B; writes_acc_o = 1'b1; end
      OP_ADD: begin alu_op_o = ALU_ADD;    writes_acc_o = 1'b1; end
      OP_SUB: begin alu_op_o = ALU_SUB;    writes_acc_o = 1'b1; end
      OP_AND: begin alu_op_o = ALU_AND;    writes_acc_o = 1'b1; end
      OP_OR:  begin alu_op_o = ALU_OR;     writes_acc_o = 1'b1; end
      OP_XOR: begin alu_op_o = ALU_XOR;    writes_acc_o = 1'b1; end
      OP_NOT: begin alu_op_o = ALU_NOT_A;  writes_acc_o = 1'b1; end
      OP_JMP: is_jmp_o = 1'b1;
      OP_JZ:  is_jz_o  = 1'b1;
      OP_HLT: is_hlt_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu4_seq.sv
// Fetch/execute sequencer for the 4-bit microprocessor.
// FETCH -> EXEC -> WRITE for ALU-class ops, FETCH -> EXEC for jumps/HLT.
// All outputs come straight from flops; next values are computed from the
// next state so each strobe lines up with the state it belongs to.
// Optional build macro SINGLE_STEP_EN adds step_i: after each instruction
// the sequencer parks in STEP_WAIT until step_i is seen high.
import cpu4_pkg::*;

module cpu4_seq #(
  parameter int PC_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
`ifdef SINGLE_STEP_EN
  input  logic               step_i,
`endif
  input  logic               start_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               acc_zero_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               ir_ld_o,
  output logic [2:0]         alu_op_o,
  output logic [DATA_W-1:0]  operand_o,
  output logic               acc_ld_o,
  output logic               busy_o,
  output logic               halted_o
);

  state_t               state_q, state_d;
  state_t               next_fetch;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic [DATA_W-1:0]    operand_q, operand_d;
  logic                 ir_ld_q, ir_ld_d;
  logic                 acc_ld_q, acc_ld_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;

  logic [3:0]           dec_opcode;
  logic [2:0]           dec_alu_op;
  logic                 dec_writes_acc;
  logic                 dec_is_jmp;
  logic                 dec_is_jz;
  logic                 dec_is_hlt;
  logic [PC_W-1:0]      imm_pc;
  logic [PC_W-1:0]      pc_inc;

  // In FETCH decode the word arriving from memory (to register alu_op for
  // EXEC); otherwise decode the captured instruction.
  assign dec_opcode = (state_q == S_FETCH) ? instr_i[7:4] : ir_q[7:4];
  assign imm_pc     = PC_W'(ir_q[3:0]);
  assign pc_inc     = pc_q + PC_W'(1);

`ifdef SINGLE_STEP_EN
  assign next_fetch = step_i ? S_FETCH : S_STEP_WAIT;
`else
  assign next_fetch = S_FETCH;
`endif

  cpu4_dec u_dec (
    .opcode_i     (dec_opcode),
    .alu_op_o     (dec_alu_op),
    .writes_acc_o (dec_writes_acc),
    .is_jmp_o     (dec_is_jmp),
    .is_jz_o      (dec_is_jz),
    .is_hlt_o     (dec_is_hlt)
  );

  // State, PC, IR and registered outputs; reset clears everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      alu_op_q  <= '0;
      operand_q <= '0;
      ir_ld_q   <= 1'b0;
      acc_ld_q  <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      operand_q <= operand_d;
      ir_ld_q   <= ir_ld_d;
      acc_ld_q  <= acc_ld_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state, PC/IR update and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d      = instr_i;
        alu_op_d  = dec_alu_op;
        operand_d = instr_i[3:0];
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (dec_is_hlt) begin
          state_d = S_HALT;
        end else if (dec_is_jmp) begin
          pc_d    = imm_pc;
          state_d = next_fetch;
        end else if (dec_is_jz) begin
          pc_d    = acc_zero_i ? imm_pc : pc_inc;
          state_d = next_fetch;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        pc_d    = pc_inc;
        state_d = next_fetch;
      end
`ifdef SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step_i) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // acc_ld rises on WRITE entry, one edge after alu_op settled on EXEC entry.
    ir_ld_d  = (state_d == S_FETCH);
    acc_ld_d = (state_q == S_EXEC) && (state_d == S_WRITE) && dec_writes_acc;
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WRITE);
    halted_d = (state_d == S_HALT);
  end

  assign pc_o      = pc_q;
  assign ir_ld_o   = ir_ld_q;
  assign alu_op_o  = alu_op_q;
  assign operand_o = operand_q;
  assign acc_ld_o  = acc_ld_q;
  assign busy_o    = busy_q;
  assign halted_o  = halted_q;

endmodule

// File: tb/tb_cpu4_seq.sv
// Self-checking bench for cpu4_seq: a small accumulator datapath reacts to
// the sequencer's strobes, while an instruction-level model tracks the
// expected PC and accumulator per instruction.
module tb_cpu4_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
`ifdef SINGLE_STEP_EN
  logic       step_i = 1'b1;
`endif
  logic [7:0] instr_i;
  logic       acc_zero_i;
  logic [3:0] pc_o;
  logic       ir_ld_o;
  logic [2:0] alu_op_o;
  logic [3:0] operand_o;
  logic       acc_ld_o;
  logic       busy_o;
  logic       halted_o;

  logic [7:0] mem [16];
  logic [3:0] acc_env;
  logic [3:0] pc_m;
  logic [3:0] acc_m;
  int n_checks = 0;
  int n_fail   = 0;
  int n_ld     = 0;
  int n_ir     = 0;
  int cyc      = 0;

  cpu4_seq #(.PC_W(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
`ifdef SINGLE_STEP_EN
    .step_i     (step_i),
`endif
    .start_i    (start_i),
    .instr_i    (instr_i),
    .acc_zero_i (acc_zero_i),
    .pc_o       (pc_o),
    .ir_ld_o    (ir_ld_o),
    .alu_op_o   (alu_op_o),
    .operand_o  (operand_o),
    .acc_ld_o   (acc_ld_o),
    .busy_o     (busy_o),
    .halted_o   (halted_o)
  );

  always #5 clk_i = ~clk_i;

  assign instr_i    = mem[pc_o];
  assign acc_zero_i = (acc_env == 4'd0);

  // Environment ALU + accumulator driven purely by the sequencer outputs.
  function automatic logic [3:0] env_alu(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    case (f)
      3'd0: return b;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  always @(posedge clk_i or posedge rst_i)
    if (rst_i) acc_env <= 4'd0;
    else if (acc_ld_o) acc_env <= env_alu(alu_op_o, acc_env, operand_o);

  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    if (acc_ld_o) n_ld++;
    if (ir_ld_o) n_ir++;
  end

  // Instruction-set semantics of the accumulator.
  function automatic logic [3:0] isa_acc(input logic [3:0] op, input logic [3:0] a, input logic [3:0] imm);
    case (op)
      4'h1: return imm;
      4'h2: return a + imm;
      4'h3: return a - imm;
      4'h4: return a & imm;
      4'h5: return a | imm;
      4'h6: return a ^ imm;
      4'h7: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic step_clk();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step_clk();
    rst_i = 1'b0;
    pc_m  = 4'd0;
    acc_m = 4'd0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step_clk();
    start_i = 1'b0;
  endtask

  // Called while the DUT sits in FETCH; returns at the following FETCH
  // (or STEP_WAIT), or in HALT with hlt=1.
  task automatic exec_one(output bit hlt);
    logic [3:0] op, imm;
    logic [2:0] exp_alu;
    op  = mem[pc_m][7:4];
    imm = mem[pc_m][3:0];
    exp_alu = 3'(op - 4'd1);
    hlt = 1'b0;
    n_checks++;
    if (ir_ld_o !== 1'b1 || busy_o !== 1'b1 || acc_ld_o !== 1'b0 || pc_o !== pc_m) begin
      n_fail++;
      $display("FAIL fetch: ir_ld=%b busy=%b acc_ld=%b pc=%h, required 1 1 0 %h", ir_ld_o, busy_o, acc_ld_o, pc_o, pc_m);
    end
    step_clk();
    n_checks++;
    if (ir_ld_o !== 1'b0 || busy_o !== 1'b1 || acc_ld_o !== 1'b0 || operand_o !== imm) begin
      n_fail++;
      $display("FAIL exec: ir_ld=%b busy=%b acc_ld=%b operand=%h, required 0 1 0 %h", ir_ld_o, busy_o, acc_ld_o, operand_o, imm);
    end
    if (op >= 4'h1 && op <= 4'h7) begin
      n_checks++;
      if (alu_op_o !== exp_alu) begin
        n_fail++;
        $display("FAIL exec_alu_op: op=%h alu_op=%0d, required %0d", op, alu_op_o, exp_alu);
      end
    end
    if (op == 4'hF) begin
      step_clk();
      n_checks++;
      if (halted_o !== 1'b1 || busy_o !== 1'b0 || pc_o !== pc_m || ir_ld_o !== 1'b0) begin
        n_fail++;
        $display("FAIL halt: halted=%b busy=%b pc=%h ir_ld=%b, required 1 0 %h 0", halted_o, busy_o, pc_o, ir_ld_o, pc_m);
      end
      hlt = 1'b1;
      return;
    end
    if (op == 4'h8) pc_m = imm;
    else if (op == 4'h9) pc_m = (acc_m == 4'd0) ? imm : pc_m + 4'd1;
    else begin
      step_clk();
      n_checks++;
      if (acc_ld_o !== (op >= 4'h1 && op <= 4'h7) || busy_o !== 1'b1 || operand_o !== imm) begin
        n_fail++;
        $display("FAIL write: op=%h acc_ld=%b busy=%b operand=%h, required %b 1 %h", op, acc_ld_o, busy_o, operand_o, (op >= 4'h1 && op <= 4'h7), imm);
      end
      acc_m = isa_acc(op, acc_m, imm);
      pc_m  = pc_m + 4'd1;
    end
    step_clk();
    n_checks++;
    if (acc_env !== acc_m) begin
      n_fail++;
      $display("FAIL acc_value: op=%h acc=%h, required %h", op, acc_env, acc_m);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    n_checks++;
    if (pc_o !== 4'd0 || ir_ld_o !== 1'b0 || alu_op_o !== 3'd0 || operand_o !== 4'd0 ||
        acc_ld_o !== 1'b0 || busy_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: pc=%h ir_ld=%b alu=%0d opd=%h acc_ld=%b busy=%b halted=%b, required all 0",
               pc_o, ir_ld_o, alu_op_o, operand_o, acc_ld_o, busy_o, halted_o);
    end
    do_reset();
    step_clk();
    n_checks++;
    if (busy_o !== 1'b0 || ir_ld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b ir_ld=%b, required 0 0", busy_o, ir_ld_o);
    end
  endtask

  task automatic test_program();
    bit hlt;
    int c0, ld0;
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hF0;
    do_reset();
    ld0 = n_ld;
    do_start();
    c0 = cyc;
    for (int i = 0; i < 3; i++) exec_one(hlt);
    n_checks++;
    if (cyc - c0 !== 8 || pc_o !== 4'd2 || acc_env !== 4'd8 || n_ld - ld0 !== 2 || halted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL program_result: cycles=%0d pc=%h acc=%h loads=%0d halted=%b, required 8 2 8 2 1",
               cyc - c0, pc_o, acc_env, n_ld - ld0, halted_o);
    end
    do_start();
    exec_one(hlt);
    n_checks++;
    if (hlt !== 1'b1 || pc_o !== 4'd2) begin
      n_fail++;
      $display("FAIL halt_restart: halted=%b pc=%h, required 1 2", hlt, pc_o);
    end
  endtask

  task automatic test_jz();
    bit hlt;
    int ld0;
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[0] = (k == 0) ? 8'h10 : 8'h11;
      mem[1] = 8'h96;
      do_reset();
      ld0 = n_ld;
      do_start();
      exec_one(hlt);
      exec_one(hlt);
      n_checks++;
      if (pc_o !== ((k == 0) ? 4'd6 : 4'd2) || n_ld - ld0 !== 1) begin
        n_fail++;
        $display("FAIL jz_target_%0d: pc=%h loads=%0d, required %h 1", k, pc_o, n_ld - ld0, (k == 0) ? 4'd6 : 4'd2);
      end
    end
  endtask

  task automatic test_wrap();
    bit hlt;
    logic [3:0] exp_pc [4];
    exp_pc = '{4'hF, 4'h0, 4'hF, 4'h0};
    clear_mem();
    mem[0] = 8'h8F;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      exec_one(hlt);
      n_checks++;
      if (pc_o !== exp_pc[i]) begin
        n_fail++;
        $display("FAIL wrap_pc_%0d: pc=%h, required %h", i, pc_o, exp_pc[i]);
      end
    end
  endtask

  task automatic test_illegal();
    bit hlt;
    int ld0, ir0, c0;
    for (int op = 10; op <= 14; op++) begin
      clear_mem();
      mem[0] = {4'(op), 4'(op)};
      do_reset();
      ld0 = n_ld;
      ir0 = n_ir;
      do_start();
      c0 = cyc;
      exec_one(hlt);
      n_checks++;
      if (pc_o !== 4'd1 || n_ld - ld0 !== 0 || n_ir - ir0 !== 1 || cyc - c0 !== 3) begin
        n_fail++;
        $display("FAIL illegal_%h: pc=%h loads=%0d ir_loads=%0d cycles=%0d, required 1 0 1 3",
                 op, pc_o, n_ld - ld0, n_ir - ir0, cyc - c0);
      end
    end
  endtask

  task automatic test_async_reset();
    bit hlt;
    int ld0;
    clear_mem();
    mem[0] = 8'h17; mem[1] = 8'h32;
    do_reset();
    do_start();
    exec_one(hlt);
    step_clk();
    #3;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (pc_o !== 4'd0 || ir_ld_o !== 1'b0 || alu_op_o !== 3'd0 || operand_o !== 4'd0 ||
        acc_ld_o !== 1'b0 || busy_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h ir_ld=%b alu=%0d opd=%h acc_ld=%b busy=%b halted=%b, required all 0",
               pc_o, ir_ld_o, alu_op_o, operand_o, acc_ld_o, busy_o, halted_o);
    end
    step_clk();
    rst_i = 1'b0;
    ld0 = n_ld;
    repeat (5) step_clk();
    n_checks++;
    if (n_ld - ld0 !== 0 || busy_o !== 1'b0 || pc_o !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: loads=%0d busy=%b pc=%h, required 0 0 0", n_ld - ld0, busy_o, pc_o);
    end
    // Simultaneous reset and start: reset wins.
    rst_i = 1'b1;
    start_i = 1'b1;
    step_clk();
    rst_i = 1'b0;
    start_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || ir_ld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_beats_start: busy=%b ir_ld=%b, required 0 0", busy_o, ir_ld_o);
    end
  endtask

  task automatic test_random();
    bit hlt;
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      do_reset();
      do_start();
      hlt = 1'b0;
      for (int n = 0; n < 25 && !hlt; n++) exec_one(hlt);
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    bit hlt;
    int ir0;
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h21; mem[2] = 8'h21; mem[3] = 8'hF0;
    step_i = 1'b0;
    do_reset();
    do_start();
    exec_one(hlt);
    for (int s = 0; s < 3; s++) begin
      ir0 = n_ir;
      repeat (4) step_clk();
      n_checks++;
      if (busy_o !== 1'b0 || n_ir - ir0 !== 0 || pc_o !== pc_m || acc_ld_o !== 1'b0) begin
        n_fail++;
        $display("FAIL step_wait_%0d: busy=%b ir_loads=%0d pc=%h, required 0 0 %h", s, busy_o, n_ir - ir0, pc_o, pc_m);
      end
      step_i = 1'b1;
      step_clk();
      step_i = 1'b0;
      exec_one(hlt);
    end
    n_checks++;
    if (hlt !== 1'b1 || acc_env !== 4'd3) begin
      n_fail++;
      $display("FAIL step_result: halted=%b acc=%h, required 1 3", hlt, acc_env);
    end
    step_i = 1'b1;
  endtask
`endif

  initial begin
    clear_mem();
    pc_m  = 4'd0;
    acc_m = 4'd0;
    test_reset();
    test_program();
    test_jz();
    test_wrap();
    test_illegal();
    test_async_reset();
    test_random();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
